// File: rtl/alu_exec_stage_if.sv
// Request/response bundle between the execute-stage ALU and its neighbours.
interface alu_exec_stage_if #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned SHAMT_W = 5
);
   logic               in_valid;
   logic               in_ready;
   logic [3:0]         alu_op;
   logic [WIDTH-1:0]   operand_a;
   logic [WIDTH-1:0]   operand_b;
   logic [SHAMT_W-1:0] shamt;
   logic               out_valid;
   logic               out_ready;
   logic [WIDTH-1:0]   result;
   logic               zero;
   logic               overflow;
   logic               illegal_op;

   // Requester / result consumer side
   modport master (
      output in_valid, alu_op, operand_a, operand_b, shamt, out_ready,
      input  in_ready, out_valid, result, zero, overflow, illegal_op
   );

   // ALU side
   modport slave (
      input  in_valid, alu_op, operand_a, operand_b, shamt, out_ready,
      output in_ready, out_valid, result, zero, overflow, illegal_op
   );
endinterface

// File: rtl/alu_exec_stage.sv
// Execute-stage ALU: single-cycle logic/arith ops, iterative 1-bit/cycle shifts,
// registered result with zero/overflow/illegal flags over valid/ready.
module alu_exec_stage #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned SHAMT_W = 5
) (
   input logic clk,
   input logic rst,
   alu_exec_stage_if.slave bus
);
   localparam int unsigned MSB = WIDTH - 1;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t             r_state;
   state_t             w_next;
   logic [WIDTH-1:0]   r_result;
   logic               r_zero;
   logic               r_ovf;
   logic               r_ill;
   logic [WIDTH-1:0]   r_shreg;
   logic [SHAMT_W-1:0] r_count;
   logic [1:0]         r_shop;

   logic               w_accept;
   logic [WIDTH-1:0]   w_sum;
   logic [WIDTH-1:0]   w_diff;
   logic [WIDTH-1:0]   w_res;
   logic               w_ovf;
   logic               w_ill;
   logic               w_is_shift;
   logic               w_shift_now;
   logic [WIDTH-1:0]   w_shifted;

   // One-bit shift step; kind taken from alu_op[1:0] (00 sll, 01 srl, 10 sra)
   function automatic logic [WIDTH-1:0] shift1(input logic [WIDTH-1:0] v, input logic [1:0] k);
      case (k)
         2'b00:   shift1 = v << 1;
         2'b01:   shift1 = v >> 1;
         default: shift1 = {v[MSB], v[MSB:1]};
      endcase
   endfunction

   // Single-cycle operation decode and evaluation on the live request
   always_comb begin
      w_sum      = bus.operand_a + bus.operand_b;
      w_diff     = bus.operand_a - bus.operand_b;
      w_res      = '0;
      w_ovf      = 1'b0;
      w_ill      = 1'b0;
      w_is_shift = 1'b0;
      case (bus.alu_op)
         4'b0010: begin
            w_res = w_sum;
            w_ovf = (bus.operand_a[MSB] == bus.operand_b[MSB]) && (w_sum[MSB] != bus.operand_a[MSB]);
         end
         4'b0110: begin
            w_res = w_diff;
            w_ovf = (bus.operand_a[MSB] != bus.operand_b[MSB]) && (w_diff[MSB] != bus.operand_a[MSB]);
         end
         4'b0000: w_res = bus.operand_a & bus.operand_b;
         4'b0001: w_res = bus.operand_a | bus.operand_b;
         4'b0011: w_res = bus.operand_a ^ bus.operand_b;
         4'b1100: w_res = ~(bus.operand_a | bus.operand_b);
         4'b0111: w_res = {{(WIDTH-1){1'b0}}, ($signed(bus.operand_a) < $signed(bus.operand_b))};
         4'b1110: w_res = {{(WIDTH-1){1'b0}}, (bus.operand_a < bus.operand_b)};
         4'b1000, 4'b1001, 4'b1010: begin
            // shamt==0 completes in one cycle with the unshifted source
            w_is_shift = 1'b1;
            w_res      = bus.operand_b;
         end
         default: w_ill = 1'b1;
      endcase
   end

   assign w_accept    = bus.in_valid && (r_state == IDLE);
   assign w_shift_now = w_is_shift && (bus.shamt != '0);
   assign w_shifted   = shift1(r_shreg, r_shop);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_next = w_shift_now ? SHIFT : DONE;
         SHIFT:   if (r_count == SHAMT_W'(1)) w_next = DONE;
         DONE:    if (bus.out_ready) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Outputs: handshake from state, result/flags straight from registers
   always_comb begin
      bus.in_ready   = (r_state == IDLE);
      bus.out_valid  = (r_state == DONE);
      bus.result     = r_result;
      bus.zero       = r_zero;
      bus.overflow   = r_ovf;
      bus.illegal_op = r_ill;
   end

   // Datapath: capture at accept, iterate shifts, publish result on DONE entry
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_result <= '0;
         r_zero   <= 1'b0;
         r_ovf    <= 1'b0;
         r_ill    <= 1'b0;
         r_shreg  <= '0;
         r_count  <= '0;
         r_shop   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_ovf  <= w_ovf;
                  r_ill  <= w_ill;
                  r_shop <= bus.alu_op[1:0];
                  if (w_shift_now) begin
                     r_shreg <= bus.operand_b;
                     r_count <= bus.shamt;
                  end else begin
                     r_result <= w_res;
                     r_zero   <= (w_res == '0);
                  end
               end
            end
            SHIFT: begin
               r_shreg <= w_shifted;
               r_count <= r_count - SHAMT_W'(1);
               if (r_count == SHAMT_W'(1)) begin
                  r_result <= w_shifted;
                  r_zero   <= (w_shifted == '0);
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed scoreboard bench for alu_exec_stage.
module tb_alu_exec_stage;
   typedef struct {
      logic [31:0] res;
      logic        z;
      logic        ov;
      logic        il;
      int unsigned lat;
   } exp_t;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_err;
   exp_t sb[$];

   alu_exec_stage_if #(.WIDTH(32), .SHAMT_W(5)) bus ();

   alu_exec_stage #(.WIDTH(32), .SHAMT_W(5)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh, input logic [31:0] er, input logic eo,
                        input logic ei, input bit push);
      exp_t e;
      chk("in_ready_idle", {31'b0, bus.in_ready}, 32'd1);
      bus.in_valid  = 1'b1;
      bus.alu_op    = op;
      bus.operand_a = a;
      bus.operand_b = b;
      bus.shamt     = sh;
      @(posedge clk);
      #1;
      bus.in_valid  = 1'b0;
      bus.alu_op    = 4'b0010;
      bus.operand_a = $urandom;
      bus.operand_b = $urandom;
      bus.shamt     = 5'($urandom);
      if (push) begin
         e.res = er;
         e.z   = (er == 32'd0);
         e.ov  = eo;
         e.il  = ei;
         e.lat = ((op == 4'b1000 || op == 4'b1001 || op == 4'b1010) && sh != 5'd0) ? int'(sh) + 1 : 1;
         sb.push_back(e);
      end
   endtask

   task automatic collect(input int hold);
      int   cyc;
      bit   rdy_seen;
      exp_t e;
      cyc      = 0;
      rdy_seen = 1'b0;
      do begin
         @(negedge clk);
         cyc++;
         if (bus.in_ready !== 1'b0) rdy_seen = 1'b1;
      end while (bus.out_valid !== 1'b1 && cyc < 64);
      chk("out_valid_timeout", {31'b0, bus.out_valid}, 32'd1);
      if (sb.size() == 0) begin
         n_cmp++;
         n_err++;
         $error("FAIL scoreboard: observed empty queue expected pending entry");
         return;
      end
      e = sb.pop_front();
      chk("latency", 32'(cyc), 32'(e.lat));
      chk("in_ready_busy", {31'b0, rdy_seen}, 32'd0);
      chk("result", bus.result, e.res);
      chk("zero", {31'b0, bus.zero}, {31'b0, e.z});
      chk("overflow", {31'b0, bus.overflow}, {31'b0, e.ov});
      chk("illegal_op", {31'b0, bus.illegal_op}, {31'b0, e.il});
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("hold_valid", {31'b0, bus.out_valid}, 32'd1);
         chk("hold_ready", {31'b0, bus.in_ready}, 32'd0);
         chk("hold_result", bus.result, e.res);
         chk("hold_overflow", {31'b0, bus.overflow}, {31'b0, e.ov});
         chk("hold_zero", {31'b0, bus.zero}, {31'b0, e.z});
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      @(negedge clk);
      chk("valid_drop", {31'b0, bus.out_valid}, 32'd0);
      chk("ready_return", {31'b0, bus.in_ready}, 32'd1);
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.alu_op    = 4'b0000;
      bus.operand_a = '0;
      bus.operand_b = '0;
      bus.shamt     = '0;
      #1;
      chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
      chk("rst_result", bus.result, 32'd0);
      chk("rst_zero", {31'b0, bus.zero}, 32'd0);
      chk("rst_overflow", {31'b0, bus.overflow}, 32'd0);
      chk("rst_illegal", {31'b0, bus.illegal_op}, 32'd0);
      chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
      @(negedge clk);
      rst = 1'b0;

      // add overflow with 3 cycles of backpressure
      issue(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0, 32'h8000_0000, 1'b1, 1'b0, 1'b1);
      collect(3);
      issue(4'b0110, 32'd5, 32'd5, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1);
      collect(0);
      issue(4'b0110, 32'h8000_0000, 32'd1, 5'd0, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b1);
      collect(0);
      issue(4'b0111, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd1, 1'b0, 1'b0, 1'b1);
      collect(0);
      issue(4'b1110, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1);
      collect(0);
      issue(4'b1100, 32'd0, 32'd0, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1);
      collect(0);
      issue(4'b0000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd0, 32'h00F0_00F0, 1'b0, 1'b0, 1'b1);
      collect(0);
      issue(4'b0001, 32'hF0F0_F0F0, 32'h0F0F_0000, 5'd0, 32'hFFFF_F0F0, 1'b0, 1'b0, 1'b1);
      collect(0);
      issue(4'b0011, 32'hA5A5_A5A5, 32'hFFFF_0000, 5'd0, 32'h5A5A_A5A5, 1'b0, 1'b0, 1'b1);
      collect(0);
      issue(4'b1010, 32'd0, 32'h8000_0000, 5'd4, 32'hF800_0000, 1'b0, 1'b0, 1'b1);
      collect(0);
      issue(4'b1000, 32'd0, 32'h0000_1234, 5'd16, 32'h1234_0000, 1'b0, 1'b0, 1'b1);
      collect(0);
      issue(4'b1001, 32'd0, 32'hABCD_0000, 5'd0, 32'hABCD_0000, 1'b0, 1'b0, 1'b1);
      collect(0);
      issue(4'b1001, 32'd0, 32'h8000_0000, 5'd31, 32'h0000_0001, 1'b0, 1'b0, 1'b1);
      collect(0);
      issue(4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b1);
      collect(2);
      issue(4'b0010, 32'd2, 32'd3, 5'd0, 32'd5, 1'b0, 1'b0, 1'b1);
      collect(0);

      // reset in the middle of a long shift: nothing may come out
      issue(4'b1010, 32'd0, 32'h8000_0000, 5'd20, 32'd0, 1'b0, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      chk("shift_in_ready", {31'b0, bus.in_ready}, 32'd0);
      chk("shift_out_valid", {31'b0, bus.out_valid}, 32'd0);
      #2;
      rst = 1'b1;
      #1;
      chk("abort_out_valid", {31'b0, bus.out_valid}, 32'd0);
      chk("abort_result", bus.result, 32'd0);
      chk("abort_in_ready", {31'b0, bus.in_ready}, 32'd1);
      @(negedge clk);
      rst = 1'b0;
      begin
         bit stray;
         stray = 1'b0;
         repeat (25) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) stray = 1'b1;
         end
         chk("abort_no_result", {31'b0, stray}, 32'd0);
      end
      chk("abort_result_idle", bus.result, 32'd0);
      chk("abort_ready_idle", {31'b0, bus.in_ready}, 32'd1);

      issue(4'b0110, 32'h0000_0010, 32'h0000_0001, 5'd0, 32'h0000_000F, 1'b0, 1'b0, 1'b1);
      collect(0);

      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
- Execute-stage ALU for the MIPS datapath.
- Consumes the 4-bit ALU_Operation code from the ALU control decoder plus register/immediate operands.
- Produces a registered result with zero, overflow and illegal-op flags over a valid/ready handshake.
- Shifts are iterative, one bit per cycle, so latency is variable; all other ops take 1 cycle.

Parameters:
- WIDTH, 32, datapath width in bits.
- SHAMT_W, 5, shift-amount width (must satisfy 2**SHAMT_W >= WIDTH).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  stage can accept a request.
- alu_op  in  4  ALU_Operation code.
- operand_a  in  WIDTH  rs value.
- operand_b  in  WIDTH  rt value or extended immediate; this is the shift source.
- shamt  in  SHAMT_W  shift amount.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  registered result.
- zero  out  1  result == 0, used for beq.
- overflow  out  1  signed overflow for add/sub.
- illegal_op  out  1  unsupported alu_op.

Behaviour:
- Reset (async, immediate): state=IDLE; out_valid, result, zero, overflow, illegal_op all 0.
  - Reset mid-shift or mid-DONE aborts the operation; no result is emitted.
- FSM states: IDLE, SHIFT, DONE. in_ready=1 only in IDLE.
- Accept occurs on in_valid && in_ready. alu_op, operands and shamt are sampled only at accept; later input changes are ignored.
- IDLE, on accept:
  - Non-shift op: compute, register result/flags, go to DONE. out_valid is high the cycle after accept (latency 1).
  - Shift op (1000, 1001, 1010) with shamt==0: result=operand_b, go to DONE (latency 1).
  - Shift op with shamt!=0: load shift reg=operand_b, count=shamt, go to SHIFT.
- SHIFT: each cycle shift 1 bit and decrement count. After the final shift, move to DONE.
  - out_valid rises exactly shamt+1 cycles after accept.
  - result/zero update on DONE entry only.
- DONE: out_valid=1; result and flags held stable while out_ready=0.
  - On out_ready, return to IDLE. out_valid drops the next cycle.
  - A new accept is possible no earlier than the cycle after the handshake, giving max throughput of 1 op per 2 cycles.
- Op codes:
  - 0010 add: a+b, wrap mod 2^WIDTH.
  - 0110 sub: a-b, wrap mod 2^WIDTH.
  - 0000 and.
  - 0001 or.
  - 0011 xor.
  - 1100 nor.
  - 0111 slt: signed a<b gives 1, else 0, zero-extended.
  - 1110 sltu: unsigned compare, otherwise as slt.
  - 1000 sll: b<<shamt, zero fill. Also lui: the datapath drives b=imm and shamt=16.
  - 1001 srl: b>>shamt, zero fill.
  - 1010 sra: b>>shamt, sign fill from b[WIDTH-1].
  - Any other code (incl. 1111, 4'bx treated as illegal): result=0, illegal_op=1, latency 1.
- overflow: 1 only for add/sub when operand signs produce a wrong result sign:
  - add: a,b same sign and result sign differs.
  - sub: a,b differ in sign and result sign != a sign.
  - 0 for all other ops. The result is still written (no trap here).
- zero = (result==0), registered with result. Valid only while out_valid; held when not valid.
- Flags are cleared to 0 on each new accept for ops that do not set them.

Test Plan:
- add a=0x7FFFFFFF, b=1 -> result 0x80000000, overflow=1, zero=0, out_valid 1 cycle after accept.
- sub a=5, b=5 -> result 0, zero=1, overflow=0. sub 0x80000000-1 -> 0x7FFFFFFF, overflow=1.
- slt a=0xFFFFFFFF, b=1 -> 1. sltu same operands -> 0. nor 0,0 -> 0xFFFFFFFF.
- sra b=0x80000000, shamt=4 -> 0xF8000000, out_valid exactly 5 cycles after accept, in_ready=0 throughout. sll b=0x1234, shamt=16 -> 0x12340000. srl with shamt=0 -> b, latency 1.
- Backpressure and reset:
  - Hold out_ready=0 for 3 cycles in DONE -> result/flags stable, in_ready=0. Release -> IDLE next cycle.
  - Assert rst during SHIFT -> out_valid=0 immediately, in_ready=1 after release, no stale result.
- alu_op=1111 -> illegal_op=1, result 0, out_valid after 1 cycle. The next legal op clears illegal_op.
